// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/memory sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_pkg;

    // RUN sequences the pipeline; HALT is terminal until reset.
    typedef enum logic {HZ_RUN, HZ_HALT} hz_state_t;

    // Register specifier zero is hardwired and never creates a dependency.
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Cache port shared between instruction fetch and data access.
// Latency: combinational request strobes, hits come back from the cache.
// Backpressure: a request stays asserted until its matching hit strobe.
interface hazard_ctrl_if;
    logic ihit;
    logic dhit;
    logic imemREN;
    logic dmemREN;
    logic dmemWEN;

    modport master (input ihit, input dhit, output imemREN, output dmemREN, output dmemWEN);
    modport slave  (output ihit, output dhit, input imemREN, input dmemREN, input dmemWEN);
endinterface

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter for hazard statistics.
// Latency: count visible the cycle after the increment strobe.
// Backpressure: none; sticks at all-ones instead of wrapping.
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;

    // Count events, holding at the maximum value.
    always_ff @(posedge CLK) begin
        if (RST)
            cnt_q <= '0;
        else if (inc && (cnt_q != '1))
            cnt_q <= cnt_q + CNT_W'(1);
    end

    // Output reads zero during the reset cycle itself.
    assign cnt = RST ? '0 : cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/memory sequencer: arbitrates the cache port, drives latch enables/flushes, halt drain, watchdog.
// Latency: all strobes combinational from registered state plus inputs; state updates next edge.
// Backpressure: any outstanding cache miss stalls every latch. Macro HAZARD_PERF_EN adds perf counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 32
) (
    input  logic              CLK,
    input  logic              RST,
    hazard_ctrl_if.master     mem,
    input  logic              exme_dren,
    input  logic              exme_dwen,
    input  logic              idex_memread,
    input  logic [REG_AW-1:0] idex_rt,
    input  logic [REG_AW-1:0] ifid_rs,
    input  logic [REG_AW-1:0] ifid_rt,
    input  logic              branch_taken,
    input  logic              halt_mewb,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              halted,
    output logic              mem_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  lu_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam bit WD_EN = (TIMEOUT > 0);
    localparam int WC_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    hz_state_t        state_q, state_d;
    logic             dfin_q, dfin_d;
    logic [WC_W-1:0]  wait_q, wait_d;
    logic             mem_err_q, mem_err_d;

    logic run, active, dpend, adv, load_use, hit_acc;

    // RUN cycles that are not the halt-drain cycle and not under reset drive the port.
    assign run      = (state_q == HZ_RUN);
    assign active   = run & ~halt_mewb & ~RST;
    assign dpend    = (exme_dren | exme_dwen) & ~dfin_q;
    assign hit_acc  = dpend ? mem.dhit : mem.ihit;
    assign adv      = active & mem.ihit & ~dpend;
    assign load_use = idex_memread & (idex_rt != REG_AW'(REG_ZERO))
                    & ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

    assign mem.dmemREN = active & exme_dren & ~dfin_q;
    assign mem.dmemWEN = active & exme_dwen & ~dfin_q;
    assign mem.imemREN = active & ~dpend;

    assign exmem_en   = adv;
    assign memwb_en   = adv;
    assign idex_en    = adv;
    assign pc_en      = adv & (~load_use | branch_taken);
    assign ifid_en    = adv & (~load_use | branch_taken);
    assign idex_flush = adv & (load_use | branch_taken);
    assign ifid_flush = adv & branch_taken;

    assign halted  = (state_q == HZ_HALT) & ~RST;
    assign mem_err = mem_err_q & ~RST;

    // Next-state: data-done flag, watchdog wait counter, halt entry.
    always_comb begin
        state_d   = state_q;
        dfin_d    = dfin_q;
        wait_d    = wait_q;
        mem_err_d = mem_err_q;
        if (run) begin
            if (halt_mewb) begin
                state_d = HZ_HALT;
            end else begin
                if (dpend & mem.dhit)
                    dfin_d = 1'b1;
                if (adv)
                    dfin_d = 1'b0;
                if (hit_acc) begin
                    wait_d = '0;
                end else if (WD_EN) begin
                    if (wait_q == WC_W'(TIMEOUT - 1)) begin
                        mem_err_d = 1'b1;
                        state_d   = HZ_HALT;
                    end else begin
                        wait_d = wait_q + WC_W'(1);
                    end
                end
            end
        end
    end

    // Sequencer state registers; reset abandons any access in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= HZ_RUN;
            dfin_q    <= 1'b0;
            wait_q    <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dfin_q    <= dfin_d;
            wait_q    <= wait_d;
            mem_err_q <= mem_err_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic stall_inc, lu_inc, flush_inc;
    assign stall_inc = run & ~RST & ~adv;
    assign lu_inc    = adv & load_use & ~branch_taken;
    assign flush_inc = adv & branch_taken;

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (.CLK(CLK), .RST(RST), .inc(stall_inc), .cnt(stall_cnt));
    hazard_perf_cnt #(.CNT_W(CNT_W)) u_lu_cnt    (.CLK(CLK), .RST(RST), .inc(lu_inc),    .cnt(lu_cnt));
    hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (.CLK(CLK), .RST(RST), .inc(flush_inc), .cnt(flush_cnt));
`else
    assign stall_cnt = '0;
    assign lu_cnt    = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a 4-cycle watchdog.
// Latency: outputs checked mid-cycle, after inputs settle and before the next edge.
// Backpressure: cache hits driven directly by the bench.
module tb_hazard_ctrl;

    logic        CLK;
    logic        RST;
    logic        exme_dren, exme_dwen, idex_memread, branch_taken, halt_mewb;
    logic [4:0]  idex_rt, ifid_rs, ifid_rt;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, halted, mem_err;
    logic [31:0] stall_cnt, lu_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    hazard_ctrl_if mem_if ();

    hazard_ctrl #(.REG_AW(5), .TIMEOUT(4), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .mem(mem_if),
        .exme_dren(exme_dren), .exme_dwen(exme_dwen),
        .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .branch_taken(branch_taken), .halt_mewb(halt_mewb),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .halted(halted), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .lu_cnt(lu_cnt), .flush_cnt(flush_cnt)
    );

    // {imemREN,dmemREN,dmemWEN,pc_en,ifid_en,idex_en,exmem_en,memwb_en,ifid_flush,idex_flush,halted,mem_err}
    logic [11:0] obs;
    assign obs = {mem_if.imemREN, mem_if.dmemREN, mem_if.dmemWEN, pc_en, ifid_en, idex_en,
                  exmem_en, memwb_en, ifid_flush, idex_flush, halted, mem_err};

    localparam logic [11:0] O_NONE  = 12'h000;
    localparam logic [11:0] O_IREQ  = 12'h800;
    localparam logic [11:0] O_ADV   = 12'h9F0;
    localparam logic [11:0] O_DRD   = 12'h400;
    localparam logic [11:0] O_DWR   = 12'h200;
    localparam logic [11:0] O_LU    = 12'h874;
    localparam logic [11:0] O_BR_LU = 12'h9FC;
    localparam logic [11:0] O_ERR   = 12'h003;
    localparam logic [11:0] O_HALT  = 12'h002;

`ifdef HAZARD_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Let combinational outputs settle, compare, then advance one clock.
    task automatic step(input string tag, input logic [11:0] exp);
        #2;
        check(tag, {20'd0, obs}, {20'd0, exp});
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1;
        mem_if.ihit = 1'b1; mem_if.dhit = 1'b1;
        exme_dren = 1'b1; exme_dwen = 1'b0; idex_memread = 1'b0; branch_taken = 1'b1;
        halt_mewb = 1'b0; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
        @(posedge CLK); #1;

        // Reset forces all outputs low even with live inputs.
        #2;
        check("rst_cnt", stall_cnt | lu_cnt | flush_cnt, 32'd0);
        step("rst_out", O_NONE);

        // 1: instruction stream only, ihit every second cycle.
        RST = 1'b0; exme_dren = 1'b0; branch_taken = 1'b0; mem_if.dhit = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mem_if.ihit = (i % 2 == 1);
            step($sformatf("ifetch%0d", i), (i % 2 == 1) ? O_ADV : O_IREQ);
        end

        // 2: store waits for dhit on cycle 3, fetch hit on cycle 5.
        exme_dwen = 1'b1; mem_if.ihit = 1'b0;
        step("st_c1", O_DWR);
        step("st_c2", O_DWR);
        mem_if.dhit = 1'b1;
        step("st_c3", O_DWR);
        mem_if.dhit = 1'b0;
        step("st_c4", O_IREQ);
        mem_if.ihit = 1'b1;
        step("st_c5", O_ADV);
        exme_dwen = 1'b0;

        // 3: load-use on rs, then rt==0, then load-use on rt.
        idex_memread = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5; ifid_rt = 5'd1;
        step("lu_rs", O_LU);
        idex_rt = 5'd0; ifid_rs = 5'd0;
        step("lu_zero", O_ADV);
        idex_rt = 5'd7; ifid_rs = 5'd3; ifid_rt = 5'd7;
        step("lu_rt", O_LU);

        // 4: branch wins over a simultaneous load-use.
        idex_rt = 5'd5; ifid_rs = 5'd5; branch_taken = 1'b1;
        step("br_lu", O_BR_LU);
        branch_taken = 1'b0; idex_memread = 1'b0;
        #2;
        check("stall_cnt", stall_cnt, 32'(7 * PERF));
        check("lu_cnt", lu_cnt, 32'(2 * PERF));
        check("flush_cnt", flush_cnt, 32'(1 * PERF));

        // 5: load never hits; watchdog fires on its fourth waiting cycle.
        exme_dren = 1'b1; mem_if.ihit = 1'b0;
        for (int i = 1; i <= 4; i++)
            step($sformatf("wd_c%0d", i), O_DRD);
        step("wd_err", O_ERR);
        RST = 1'b1;
        #2;
        check("wd_rst_cnt", stall_cnt | lu_cnt | flush_cnt, 32'd0);
        step("wd_rst", O_NONE);
        RST = 1'b0; exme_dren = 1'b0;
        step("wd_resume", O_IREQ);

        // 6: halt arrives mid data wait, then hits toggle while halted.
        exme_dren = 1'b1;
        step("hlt_wait", O_DRD);
        halt_mewb = 1'b1;
        step("hlt_drain", O_NONE);
        halt_mewb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_if.ihit = (i % 2 == 0);
            mem_if.dhit = (i % 2 == 1);
            step($sformatf("hlt_hold%0d", i), O_HALT);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
